// File: rtl/clk_divider.sv
// Programmable clock divider / tick generator with glitch-free divisor reload.
// Optional CLK_DIVIDER_PERIOD_CNT_EN adds a saturating tick counter output.
module clk_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_div_out,
  output logic             tick,
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pvld_q, pvld_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;

  logic             running;
  logic             wrap;
  logic             apply;
  logic [WIDTH-1:0] hi_len;
  logic [WIDTH-1:0] clamped;

  assign running = (state_q != IDLE);
  assign wrap    = running && (cnt_q == div_q - ONE);
  assign hi_len  = div_q - (div_q >> 1);
  assign clamped = (div_val < TWO) ? TWO : div_val;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; STOP keeps counting so a re-raised en resumes in phase
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN:  if (!en) state_d = wrap ? IDLE : STOP;
      STOP: begin
        if (en)        state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter and divisor update; new N only takes effect at a period boundary
  always_comb begin
    cnt_d  = (!running || wrap) ? '0 : cnt_q + ONE;
    div_d  = div_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    apply  = 1'b0;
    if ((!running || wrap) && div_load) begin
      div_d  = clamped;
      pvld_d = 1'b0;
      apply  = 1'b1;
    end else if ((!running || wrap) && pvld_q) begin
      div_d  = pend_q;
      pvld_d = 1'b0;
      apply  = 1'b1;
    end else if (div_load) begin
      pend_d = clamped;
      pvld_d = 1'b1;
    end
  end

  // Output decode from the current count; registered below
  always_comb begin
    out_d  = running && (cnt_q < hi_len);
    tick_d = wrap;
    busy_d = running;
    ack_d  = apply;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DEF;
      pend_q <= DEF;
      pvld_q <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      pvld_q <= pvld_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
    end
  end

`ifdef CLK_DIVIDER_PERIOD_CNT_EN
  logic [15:0] pcnt_q;

  // Ticks since reset or last divisor change, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           pcnt_q <= '0;
    else if (apply)                       pcnt_q <= '0;
    else if (tick_d && pcnt_q != 16'hFFFF) pcnt_q <= pcnt_q + 16'd1;
  end

  assign period_cnt = pcnt_q;
`endif

  assign clk_div_out = out_q;
  assign tick        = tick_q;
  assign busy        = busy_q;
  assign div_ack     = ack_q;

endmodule

// File: tb/tb_clk_divider.sv
// Directed self-checking bench for clk_divider.
// Optional CLK_DIVIDER_PERIOD_CNT_EN also checks period_cnt on reset.
module tb_clk_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_ack;
  logic       clk_div_out;
  logic       tick;
  logic       busy;
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_divider #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .div_val     (div_val),
    .div_load    (div_load),
    .div_ack     (div_ack),
    .clk_div_out (clk_div_out),
    .tick        (tick),
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
    .period_cnt  (period_cnt),
`endif
    .busy        (busy)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = 8'd0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    en       = 1'b1;
    div_load = 1'b0;
    div_val  = 8'd0;
    cyc();
    n_cmp++; if (clk_div_out !== 1'b0) begin n_err++; $display("FAIL rst_out got %b want 0", clk_div_out); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_tick got %b want 0", tick); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got %b want 0", div_ack); end
  endtask

  task automatic test_default_run;
    logic eo, et;
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (clk_div_out !== 1'b0) begin n_err++; $display("FAIL run_first_out got %b want 0", clk_div_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_first_busy got %b want 0", busy); end
    for (int k = 2; k <= 13; k++) begin
      cyc();
      eo = ((k - 2) % 4) < 2;
      et = ((k - 2) % 4) == 3;
      n_cmp++; if (clk_div_out !== eo) begin n_err++; $display("FAIL run_out[%0d] got %b want %b", k, clk_div_out, eo); end
      n_cmp++; if (tick !== et) begin n_err++; $display("FAIL run_tick[%0d] got %b want %b", k, tick, et); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy[%0d] got %b want 1", k, busy); end
      n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL run_ack[%0d] got %b want 0", k, div_ack); end
    end
  endtask

  task automatic test_load_mid;
    logic [8:0] eo, et, ea;
    eo = 9'b100111001;
    et = 9'b010000100;
    ea = 9'b000000100;
    cyc();
    div_val  = 8'd5;
    div_load = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      div_load = 1'b0;
      n_cmp++; if (clk_div_out !== eo[i]) begin n_err++; $display("FAIL load_out[%0d] got %b want %b", i, clk_div_out, eo[i]); end
      n_cmp++; if (tick !== et[i]) begin n_err++; $display("FAIL load_tick[%0d] got %b want %b", i, tick, et[i]); end
      n_cmp++; if (div_ack !== ea[i]) begin n_err++; $display("FAIL load_ack[%0d] got %b want %b", i, div_ack, ea[i]); end
    end
  endtask

  task automatic test_clamp_idle;
    logic eo, et;
    do_reset();
    div_val  = 8'd0;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    n_cmp++; if (div_ack !== 1'b1) begin n_err++; $display("FAIL clamp0_ack got %b want 1", div_ack); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clamp0_busy got %b want 0", busy); end
    cyc();
    n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL clamp0_ack_end got %b want 0", div_ack); end
    div_val  = 8'd1;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    n_cmp++; if (div_ack !== 1'b1) begin n_err++; $display("FAIL clamp1_ack got %b want 1", div_ack); end
    en = 1'b1;
    cyc();
    n_cmp++; if (clk_div_out !== 1'b0) begin n_err++; $display("FAIL clamp_first_out got %b want 0", clk_div_out); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      eo = (i % 2) == 0;
      et = (i % 2) == 1;
      n_cmp++; if (clk_div_out !== eo) begin n_err++; $display("FAIL clamp_out[%0d] got %b want %b", i, clk_div_out, eo); end
      n_cmp++; if (tick !== et) begin n_err++; $display("FAIL clamp_tick[%0d] got %b want %b", i, tick, et); end
      n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL clamp_ack[%0d] got %b want 0", i, div_ack); end
    end
  endtask

  task automatic test_double_load;
    logic [16:0] eo, et, ea;
    eo = 17'b10000111110000111;
    et = 17'b01000000001000000;
    ea = 17'b00000000001000000;
    do_reset();
    div_val  = 8'd8;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    n_cmp++; if (div_ack !== 1'b1) begin n_err++; $display("FAIL dbl_ack8 got %b want 1", div_ack); end
    en = 1'b1;
    cyc();
    cyc();
    n_cmp++; if (clk_div_out !== 1'b1) begin n_err++; $display("FAIL dbl_first_out got %b want 1", clk_div_out); end
    div_val  = 8'd6;
    div_load = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc();
      if (i == 0) div_val = 8'd9;
      if (i == 1) div_load = 1'b0;
      n_cmp++; if (clk_div_out !== eo[i]) begin n_err++; $display("FAIL dbl_out[%0d] got %b want %b", i, clk_div_out, eo[i]); end
      n_cmp++; if (tick !== et[i]) begin n_err++; $display("FAIL dbl_tick[%0d] got %b want %b", i, tick, et[i]); end
      n_cmp++; if (div_ack !== ea[i]) begin n_err++; $display("FAIL dbl_ack[%0d] got %b want %b", i, div_ack, ea[i]); end
    end
  endtask

  task automatic test_stop;
    logic [4:0] eo, et, eb;
    eo = 5'b00001;
    et = 5'b00100;
    eb = 5'b00111;
    do_reset();
    en = 1'b1;
    cyc();
    cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++; if (clk_div_out !== eo[i]) begin n_err++; $display("FAIL stop_out[%0d] got %b want %b", i, clk_div_out, eo[i]); end
      n_cmp++; if (tick !== et[i]) begin n_err++; $display("FAIL stop_tick[%0d] got %b want %b", i, tick, et[i]); end
      n_cmp++; if (busy !== eb[i]) begin n_err++; $display("FAIL stop_busy[%0d] got %b want %b", i, busy, eb[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] eo, et;
    eo = 7'b1001100;
    et = 7'b0100010;
    do_reset();
    en = 1'b1;
    cyc();
    cyc();
    en = 1'b0;
    cyc();
    n_cmp++; if (clk_div_out !== 1'b1) begin n_err++; $display("FAIL b2b_stop_out got %b want 1", clk_div_out); end
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      n_cmp++; if (clk_div_out !== eo[i]) begin n_err++; $display("FAIL b2b_out[%0d] got %b want %b", i, clk_div_out, eo[i]); end
      n_cmp++; if (tick !== et[i]) begin n_err++; $display("FAIL b2b_tick[%0d] got %b want %b", i, tick, et[i]); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy[%0d] got %b want 1", i, busy); end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] eo, et, eb;
    eo = 9'b001100110;
    et = 9'b100010000;
    eb = 9'b111111110;
    do_reset();
    en = 1'b1;
    cyc();
    cyc();
    div_val  = 8'd5;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (clk_div_out !== 1'b0) begin n_err++; $display("FAIL rmid_out got %b want 0", clk_div_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL rmid_ack got %b want 0", div_ack); end
`ifdef CLK_DIVIDER_PERIOD_CNT_EN
    n_cmp++; if (period_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_pcnt got %0d want 0", period_cnt); end
`endif
    #2 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      n_cmp++; if (clk_div_out !== eo[i]) begin n_err++; $display("FAIL rmid_out[%0d] got %b want %b", i, clk_div_out, eo[i]); end
      n_cmp++; if (tick !== et[i]) begin n_err++; $display("FAIL rmid_tick[%0d] got %b want %b", i, tick, et[i]); end
      n_cmp++; if (busy !== eb[i]) begin n_err++; $display("FAIL rmid_busy[%0d] got %b want %b", i, busy, eb[i]); end
      n_cmp++; if (div_ack !== 1'b0) begin n_err++; $display("FAIL rmid_ack[%0d] got %b want 0", i, div_ack); end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_load_mid();
    test_clamp_idle();
    test_double_load();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_divider.md
Name: clk_divider

Overview:
- Synchronous, programmable clock divider/tick generator on the simulation clock domain.
- Sits directly downstream of the free-running clock source and consumes its clock output.
- Produces a divided clock-like square wave and a one-cycle period tick for slower testbench and datapath stages.
- Division ratio can be changed glitch-free at run time through a load/ack handshake.

Parameters:
- WIDTH, 8, width of the divisor and internal period counter.
- DEFAULT_DIV, 4, divisor loaded on reset; must be in 2..2^WIDTH-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request; level-sensitive.
- div_val  input  WIDTH  requested divisor N.
- div_load  input  1  one-cycle strobe; captures div_val.
- div_ack  output  1  one-cycle pulse when a loaded divisor becomes active.
- clk_div_out  output  1  divided output, registered.
- tick  output  1  one-cycle pulse on the last cycle of each output period.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, active_div=DEFAULT_DIV, pend_valid=0.
  - All outputs 0.
- Clamp: any div_val of 0 or 1 is treated as 2; all other values are used as given.
- Duty: while running, clk_div_out=1 when cnt < N - floor(N/2), else 0.
  - Odd N gives a high phase one cycle longer than the low phase.
  - All outputs are registered; clk_div_out reflects cnt with one cycle of latency.
- cnt counts 0..N-1 and wraps to 0. tick=1 in the cycle where cnt==N-1.
- FSM:
  - IDLE: cnt held at 0, clk_div_out=0, busy=0. On en=1, go to RUN next cycle; first high output appears one cycle after entry.
  - RUN: count and wrap. If en=0 when cnt<N-1, go to STOP. If en=0 at cnt==N-1, go to IDLE after the wrap.
  - STOP: finish the current period normally (tick still fires), then go to IDLE at the wrap.
    - If en returns to 1 before the wrap, go back to RUN with no gap and no phase disturbance.
- Divisor load:
  - div_load=1 captures clamp(div_val) into a pending register; pend_valid=1.
  - A newer load overwrites an unapplied pending value. Only the final value is acked, with one ack total.
  - Pending values apply only at a period boundary: the edge where cnt==N-1 wraps, or immediately if in IDLE.
  - On apply, div_ack=1 for exactly one cycle and pend_valid clears.
  - If div_load coincides with the wrap cycle, the new value applies at that same wrap; the next period uses the new N.
  - A load in IDLE applies on the next edge and acks then.
- N change never truncates or extends the current period, so there are no runt pulses.
- Reset mid-period:
  - All state returns to reset values immediately.
  - Any pending load is discarded without an ack.
  - active_div returns to DEFAULT_DIV.

Optional Feature:
- Macro: CLK_DIVIDER_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt[15:0], a count of ticks emitted since reset.
  - Saturates at 16'hFFFF. Resets to 0 on rst_n.
  - Cleared on the cycle a divisor is applied.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset with DEFAULT_DIV=4, en=1 -> clk_div_out shows the pattern 1100 repeating; tick pulses every 4th cycle; busy=1.
2. Load div_val=5 mid-period while N=4 -> current period completes as 4 cycles, then a 5-cycle period with 3 high and 2 low; exactly one div_ack on the apply edge.
3. div_val=0 and then 1 loaded in IDLE -> each applies as N=2; output toggles every cycle after en=1; div_ack fires one cycle after each load.
4. Two loads (6 then 9) within one N=8 period -> only 9 applied at the wrap; a single div_ack; next period has 5 high and 4 low.
5. en dropped at cnt=1 with N=4 -> STOP; the period completes with a tick; then IDLE with output 0 and busy=0. Repeat with en re-raised at cnt=2 -> continuous output with no gap.
6. rst_n pulsed low for 3 ns mid-period with a load pending -> outputs go 0 immediately; no div_ack; N=DEFAULT_DIV after release. With CLK_DIVIDER_PERIOD_CNT_EN defined, period_cnt=0.
